dram_port_arbiter: RTL
======================

Name: dram_port_arbiter

Overview:
- Shares one external DRAM read/write port among N_REQ TileAccumUnit-style requesters, so that several accelerator instances can run on a single memory interface.
- Read addresses and writes are arbitrated round-robin.
- Each granted read address is tagged with its requester ID in an in-order tag FIFO, and returning read data is routed to the requester at the FIFO head.
- Sits between the accelerator tops and the DRAM model/controller.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- GBW, 32, global address width (TauCfg::GLOBAL_ADDR_BW).
- DBW, 16, data word width (TauCfg::DATA_BW).
- CSIZE, 32, words per DRAM beat (TauCfg::CACHE_SIZE).
- N_OUTST, 4, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_ra_rdy  in  N_REQ  per-requester read-address valid.
- o_req_ra_ack  out  N_REQ  per-requester read-address accept.
- i_req_ra  in  GBW×N_REQ  read addresses.
- o_req_rd_rdy  out  N_REQ  per-requester read-data valid.
- i_req_rd_ack  in  N_REQ  per-requester read-data accept.
- o_req_rd  out  DBW×CSIZE  read data, broadcast to all requesters.
- i_req_w_rdy  in  N_REQ  per-requester write valid.
- o_req_w_ack  out  N_REQ  per-requester write accept.
- i_req_wa  in  GBW×N_REQ  write addresses.
- i_req_wd  in  DBW×CSIZE×N_REQ  write data.
- i_req_w_mask  in  CSIZE×N_REQ  write byte/word masks.
- o_dramra_rdy  out  1  DRAM read-address valid.
- i_dramra_ack  in  1  DRAM read-address accept.
- o_dramra  out  GBW  DRAM read address.
- i_dramrd_rdy  in  1  DRAM read-data valid.
- o_dramrd_ack  out  1  DRAM read-data accept.
- i_dramrd  in  DBW×CSIZE  DRAM read data.
- o_dramw_rdy  out  1  DRAM write valid.
- i_dramw_ack  in  1  DRAM write accept.
- o_dramwa  out  GBW  DRAM write address.
- o_dramwd  out  DBW×CSIZE  DRAM write data.
- o_dramw_mask  out  CSIZE  DRAM write mask.

Behaviour:
- Handshake protocol:
  - Every channel uses rdy/ack; a transfer occurs in a cycle where rdy&&ack.
  - A rdy, once raised, holds with stable payload until acked.
  - Ack is combinational from the consumer.
  - The arbiter adds zero latency on all paths: pure mux plus registered state.
- Reset, asynchronous and effective immediately:
  - Read and write RR pointers = 0; locks cleared; tag FIFO empty (rd/wr ptr = 0, count = 0).
  - While i_rst=1, all rdy and ack outputs = 0; data outputs are don't-care.
- Read-address arbitration:
  - Candidate set = i_req_ra_rdy. Grant = first set bit searching from ra_ptr upward, modulo N_REQ.
  - o_dramra_rdy = (candidate set non-empty) && !fifo_full. o_dramra = i_req_ra[grant].
  - o_req_ra_ack[grant] = i_dramra_ack && o_dramra_rdy; all other acks = 0.
  - Lock: if o_dramra_rdy=1 and i_dramra_ack=0, register ra_lock=1 with the granted ID. While locked, grant is forced to the locked ID even if a higher-priority requester rises. This keeps downstream rdy/payload stable.
  - On transfer: ra_ptr ← grant+1 (wraps to 0 after N_REQ-1); lock cleared; grant ID pushed to the tag FIFO.
- Tag FIFO full:
  - When count == N_OUTST, o_dramra_rdy = 0 and no requester is acked.
  - The lock remains unchanged; a previously raised o_dramra_rdy must not drop. Therefore the lock is only taken when not full: a full FIFO prevents o_dramra_rdy from rising in the first place.
- Read-data routing:
  - head = FIFO[rd_ptr]. o_req_rd_rdy[head] = i_dramrd_rdy && !fifo_empty; others = 0. o_req_rd = i_dramrd.
  - o_dramrd_ack = i_req_rd_ack[head] && !fifo_empty.
  - On transfer, pop.
  - i_dramrd_rdy with an empty FIFO is a protocol error: never acked, no state change.
  - Same-cycle push and pop: count unchanged, both pointers advance. Push is allowed when full only if a pop occurs in the same cycle — no: full blocks push regardless (simple rule).
- Write arbitration:
  - Identical RR/lock scheme with an independent w_ptr and w_lock.
  - o_dramwa, o_dramwd and o_dramw_mask are muxed from the grant.
  - No FIFO and no ordering interaction with reads.

Test Plan:
- Reset mid-read: assert i_rst with 2 tags outstanding → all rdy/ack = 0 immediately; after release, count = 0 and ra_ptr = 0; the next request from req1 alone is granted to req1.
- Round-robin: both requesters hold ra_rdy, i_dramra_ack=1 every cycle → grants alternate 0,1,0,1; FIFO holds tags 0,1,0,1.
- Lock: req1 rdy, i_dramra_ack=0 for 3 cycles, req0 rises in cycle 2 with ra_ptr=0 → o_dramra stays at req1's address; req1 acked in cycle 4; req0 granted next.
- Full FIFO: 4 reads accepted without data return → o_dramra_rdy = 0 while requests are pending; one read-data transfer → o_dramra_rdy rises the next cycle.
- Read routing with backpressure: tags [1,0], i_dramrd_rdy=1, i_req_rd_ack[1]=0 for 2 cycles → o_dramrd_ack = 0 and o_req_rd_rdy = 2'b10 held; when ack[1]=1, pop; next data goes to req0.
- Write path: both w_rdy, DRAM acks alternate cycles → each write is emitted exactly once with its own address, data and mask, alternating between requesters; the payload is stable during stalls.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares one external DRAM read/write port among N_REQ accelerator
// requesters. Read addresses and writes are each arbitrated round-robin by
// an independent DramRrArbiter. Every read address that reaches the DRAM
// has its requester ID pushed into an in-order tag FIFO. Returning read data
// goes to the requester whose tag is at the FIFO head.
//
// All paths are a combinational mux plus registered arbitration and FIFO
// state, so the arbiter adds no latency.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req_ra_rdy/ra      per-requester read-address valid / addresses
//   o_req_ra_ack         per-requester read-address accept
//   o_req_rd_rdy         per-requester read-data valid
//   i_req_rd_ack         per-requester read-data accept
//   o_req_rd             read data, broadcast to all requesters
//   i_req_w_rdy/wa/wd    per-requester write valid / address / data
//   i_req_w_mask         per-requester write masks
//   o_req_w_ack          per-requester write accept
//   o_dramra_rdy/ra      DRAM read-address valid / address
//   i_dramra_ack         DRAM read-address accept
//   i_dramrd_rdy/rd      DRAM read-data valid / data
//   o_dramrd_ack         DRAM read-data accept
//   o_dramw_rdy          DRAM write valid
//   o_dramwa/wd/w_mask   DRAM write address / data / mask
//   i_dramw_ack          DRAM write accept
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// DramRrArbiter
//
// Round-robin arbiter with a grant lock for one rdy/ack channel.
// Requesters are searched upward from ptrQ. Once the downstream rdy is
// shown and not accepted, the grant is locked to that requester until the
// transfer. This keeps the downstream rdy and payload stable.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_i          per-requester valid
//   block_i        suppresses a new downstream rdy (e.g. tag FIFO full)
//   dnAck_i        downstream accept
//   dnRdy_o        downstream valid
//   grant_o        granted requester ID (payload mux select)
//   upAck_o        per-requester accept
//   fire_o         transfer happens this cycle
// ---------------------------------------------------------------------------
module DramRrArbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             block_i,
  input  logic             dnAck_i,
  output logic             dnRdy_o,
  output logic [IW-1:0]    grant_o,
  output logic [N_REQ-1:0] upAck_o,
  output logic             fire_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lockId_q, lockId_d;
  logic          found;
  logic [IW-1:0] pick;

  // Returns {found, id}: the first set request at or above start, wrapping
  // modulo N_REQ.
  function automatic logic [IW:0] rrSearch(input logic [N_REQ-1:0] req,
                                           input logic [IW-1:0]    start);
    logic          f;
    logic [IW-1:0] id;
    int            idx;
    f  = 1'b0;
    id = start;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(start) + i) % N_REQ;
      if (!f && req[idx]) begin
        f  = 1'b1;
        id = IW'(idx);
      end
    end
    return {f, id};
  endfunction

  // Round-robin search from the pointer. A held lock overrides the search,
  // so a newly raised higher-priority request cannot steal a shown grant.
  always_comb begin
    {found, pick} = rrSearch(req_i, ptr_q);
    grant_o       = lock_q ? lockId_q : pick;
  end

  // Handshake outputs. block_i only stops a new rdy from being raised.
  // When locked, block_i cannot be set: the lock is taken only while the FIFO
  // is not full, and pushes only happen on transfers, which clear the lock.
  always_comb begin
    dnRdy_o = !rst_i && !block_i && (lock_q || found);
    fire_o  = dnRdy_o && dnAck_i;
    upAck_o = fire_o ? (N_REQ'(1) << grant_o) : '0;
  end

  // A transfer moves the pointer past the winner and drops the lock. A rdy
  // that was shown but not accepted locks the current grant.
  always_comb begin
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    lockId_d = lockId_q;
    if (fire_o) begin
      ptr_d  = (grant_o == IW'(N_REQ - 1)) ? '0 : grant_o + IW'(1);
      lock_d = 1'b0;
    end else if (dnRdy_o) begin
      lock_d   = 1'b1;
      lockId_d = grant_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      lock_q   <= 1'b0;
      lockId_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      lockId_q <= lockId_d;
    end
  end

endmodule

module dram_port_arbiter #(
  parameter int N_REQ   = 2,
  parameter int GBW     = 32,
  parameter int DBW     = 16,
  parameter int CSIZE   = 32,
  parameter int N_OUTST = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  // requester read-address channel
  input  logic [N_REQ-1:0]             i_req_ra_rdy,
  output logic [N_REQ-1:0]             o_req_ra_ack,
  input  logic [GBW*N_REQ-1:0]         i_req_ra,
  // requester read-data channel
  output logic [N_REQ-1:0]             o_req_rd_rdy,
  input  logic [N_REQ-1:0]             i_req_rd_ack,
  output logic [DBW*CSIZE-1:0]         o_req_rd,
  // requester write channel
  input  logic [N_REQ-1:0]             i_req_w_rdy,
  output logic [N_REQ-1:0]             o_req_w_ack,
  input  logic [GBW*N_REQ-1:0]         i_req_wa,
  input  logic [DBW*CSIZE*N_REQ-1:0]   i_req_wd,
  input  logic [CSIZE*N_REQ-1:0]       i_req_w_mask,
  // DRAM read-address channel
  output logic                         o_dramra_rdy,
  input  logic                         i_dramra_ack,
  output logic [GBW-1:0]               o_dramra,
  // DRAM read-data channel
  input  logic                         i_dramrd_rdy,
  output logic                         o_dramrd_ack,
  input  logic [DBW*CSIZE-1:0]         i_dramrd,
  // DRAM write channel
  output logic                         o_dramw_rdy,
  input  logic                         i_dramw_ack,
  output logic [GBW-1:0]               o_dramwa,
  output logic [DBW*CSIZE-1:0]         o_dramwd,
  output logic [CSIZE-1:0]             o_dramw_mask
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (N_OUTST > 1) ? $clog2(N_OUTST) : 1;
  localparam int CW = $clog2(N_OUTST + 1);
  localparam int DW = DBW * CSIZE;

  // ---------------- tag FIFO state ----------------
  logic [IW-1:0] tagMem_q [N_OUTST];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifoFull, fifoEmpty;
  logic [IW-1:0] headId;
  logic          tagPush, tagPop;

  // ---------------- arbitration results ----------------
  logic [IW-1:0] raGrant, wGrant;
  logic          raFire, wFire;

  assign fifoFull  = (count_q == CW'(N_OUTST));
  assign fifoEmpty = (count_q == '0);
  assign headId    = tagMem_q[rdPtr_q];

  // Read-address arbiter. A full tag FIFO blocks a new rdy from being raised.
  DramRrArbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) raArb (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .req_i   (i_req_ra_rdy),
    .block_i (fifoFull),
    .dnAck_i (i_dramra_ack),
    .dnRdy_o (o_dramra_rdy),
    .grant_o (raGrant),
    .upAck_o (o_req_ra_ack),
    .fire_o  (raFire)
  );

  // Write arbiter: same scheme, with no FIFO and no ordering against reads.
  DramRrArbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) wArb (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .req_i   (i_req_w_rdy),
    .block_i (1'b0),
    .dnAck_i (i_dramw_ack),
    .dnRdy_o (o_dramw_rdy),
    .grant_o (wGrant),
    .upAck_o (o_req_w_ack),
    .fire_o  (wFire)
  );

  // Payload muxes: each arbiter's grant selects its requester's lane.
  always_comb begin
    o_dramra     = i_req_ra[raGrant*GBW +: GBW];
    o_dramwa     = i_req_wa[wGrant*GBW +: GBW];
    o_dramwd     = i_req_wd[wGrant*DW +: DW];
    o_dramw_mask = i_req_w_mask[wGrant*CSIZE +: CSIZE];
  end

  // Read data is broadcast to all requesters. Only the requester at the tag
  // FIFO head sees rdy, and only its ack returns to the DRAM. Data arriving
  // while the FIFO is empty is never acked.
  always_comb begin
    o_req_rd     = i_dramrd;
    o_req_rd_rdy = '0;
    o_dramrd_ack = 1'b0;
    if (!i_rst && !fifoEmpty) begin
      o_req_rd_rdy = i_dramrd_rdy ? (N_REQ'(1) << headId) : '0;
      o_dramrd_ack = i_req_rd_ack[headId];
    end
  end

  assign tagPush = raFire;
  assign tagPop  = i_dramrd_rdy && o_dramrd_ack;

  // FIFO pointer and count update. A push and a pop in the same cycle leave
  // the count unchanged. Push never happens while full because the arbiter
  // is blocked.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (tagPush) begin
      wrPtr_d = (wrPtr_q == PW'(N_OUTST - 1)) ? '0 : wrPtr_q + PW'(1);
    end
    if (tagPop) begin
      rdPtr_d = (rdPtr_q == PW'(N_OUTST - 1)) ? '0 : rdPtr_q + PW'(1);
    end
    case ({tagPush, tagPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Tag storage is not reset. Entries are only read after being written,
  // because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (tagPush) begin
      tagMem_q[wrPtr_q] <= raGrant;
    end
  end

endmodule
